// File: rtl/seq_emitter.sv
// Burst symbol emitter: each frame emits 1, 2, then n threes; a burst is
// rep+1 back-to-back frames followed by a one-cycle done pulse in IDLE.
module seq_emitter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] len,
    input  logic [1:0] rep,
    output logic [1:0] num,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        THREE = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] n_reg;
    logic [3:0] count;
    logic [1:0] frames_left;

    // Outputs are registered alongside the state so they always reflect it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            n_reg       <= 4'd0;
            count       <= 4'd0;
            frames_left <= 2'd0;
            num         <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= ONE;
                        n_reg       <= (len == 4'd0) ? 4'd1 : len;
                        frames_left <= rep;
                        num         <= 2'd1;
                        busy        <= 1'b1;
                    end
                end
                ONE: begin
                    state <= TWO;
                    num   <= 2'd2;
                end
                TWO: begin
                    // n is at least 1, so n-1 never underflows.
                    state <= THREE;
                    count <= n_reg - 4'd1;
                    num   <= 2'd3;
                end
                THREE: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else if (frames_left != 2'd0) begin
                        state       <= ONE;
                        frames_left <= frames_left - 2'd1;
                        num         <= 2'd1;
                    end else begin
                        state <= IDLE;
                        num   <= 2'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    num   <= 2'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_emitter.sv
// Self-checking bench for seq_emitter: directed vector table, hand-written
// corner sequences, and randomized traffic against a schedule-based model.
module tb_seq_emitter;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] len;
    logic [1:0] rep;
    logic [1:0] num;
    logic       busy;
    logic       done;

    int tests_run = 0;
    int tests_failed = 0;

    seq_emitter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .rep   (rep),
        .num   (num),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] num;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        logic       reset;
        logic       start;
        logic [3:0] len;
        logic [1:0] rep;
        logic [1:0] num;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    exp_t sched[$];
    exp_t cur;

    // Reference model: an accepted start expands the whole burst into a
    // queue of per-cycle outputs; an empty queue means the emitter is idle.
    task automatic modelStep(input logic r, input logic s, input logic [3:0] l, input logic [1:0] rp);
        int n;
        if (r) begin
            sched.delete();
            cur = '0;
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else if (s) begin
            n = (l == 0) ? 1 : int'(l);
            for (int f = 0; f <= int'(rp); f++) begin
                sched.push_back('{num: 2'd1, busy: 1'b1, done: 1'b0});
                sched.push_back('{num: 2'd2, busy: 1'b1, done: 1'b0});
                for (int k = 0; k < n; k++)
                    sched.push_back('{num: 2'd3, busy: 1'b1, done: 1'b0});
            end
            sched.push_back('{num: 2'd0, busy: 1'b0, done: 1'b1});
            cur = sched.pop_front();
        end else begin
            cur = '0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [3:0] l, input logic [1:0] rp);
        reset = r;
        start = s;
        len   = l;
        rep   = rp;
        @(posedge clk);
        modelStep(r, s, l, rp);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] en, input logic eb, input logic ed);
        tests_run++;
        if (num !== en || busy !== eb || done !== ed) begin
            tests_failed++;
            $display("[TB] FAIL %s: got num=%0d busy=%0b done=%0b, expected num=%0d busy=%0b done=%0b",
                     name, num, busy, done, en, eb, ed);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, cur.num, cur.busy, cur.done);
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void addRow(input logic r, input logic s, input logic [3:0] l, input logic [1:0] rp,
                                   input logic [1:0] n, input logic b, input logic d);
        vec_t v;
        v.reset = r; v.start = s; v.len = l; v.rep = rp;
        v.num = n; v.busy = b; v.done = d;
        vecs.push_back(v);
    endfunction

    initial begin
        int busy_cycles;
        int done_seen;
        logic r_rand;
        logic s_rand;

        reset = 1'b1;
        start = 1'b0;
        len   = 4'd0;
        rep   = 2'd0;

        // Reset with start held, then release with start low.
        addRow(1, 1, 1, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 0, 0, 0);
        addRow(0, 0, 0, 0, 0, 0, 0);
        // Single frame, len=1.
        addRow(0, 1, 1, 0, 1, 1, 0);
        addRow(0, 0, 0, 0, 2, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0, 0, 0);
        // len=0 behaves like len=1.
        addRow(0, 1, 0, 0, 1, 1, 0);
        addRow(0, 0, 0, 0, 2, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0, 0, 0);
        // Two frames of len=2.
        addRow(0, 1, 2, 1, 1, 1, 0);
        addRow(0, 0, 0, 0, 2, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 1, 1, 0);
        addRow(0, 0, 0, 0, 2, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0, 0, 0);
        // Back-to-back: start presented during the done cycle.
        addRow(0, 1, 1, 0, 1, 1, 0);
        addRow(0, 0, 0, 0, 2, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 0, 0, 1);
        addRow(0, 1, 1, 0, 1, 1, 0);
        addRow(0, 0, 0, 0, 2, 1, 0);
        addRow(0, 0, 0, 0, 3, 1, 0);
        addRow(0, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 0, 0, 0, 0, 0);
        // Inputs toggled while busy must not alter or extend the burst.
        addRow(0, 1, 1, 0, 1, 1, 0);
        addRow(0, 1, 15, 3, 2, 1, 0);
        addRow(0, 1, 15, 3, 3, 1, 0);
        addRow(0, 1, 15, 3, 0, 0, 1);
        addRow(0, 0, 15, 3, 0, 0, 0);
        addRow(0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].reset, vecs[i].start, vecs[i].len, vecs[i].rep);
            checkOutput($sformatf("vec%0d", i), vecs[i].num, vecs[i].busy, vecs[i].done);
        end

        // Reset during the second 3 of a len=4 burst, then a fresh burst.
        applyStimulus(0, 1, 4, 0); checkOutput("mid_reset_1", 1, 1, 0);
        applyStimulus(0, 0, 0, 0); checkOutput("mid_reset_2", 2, 1, 0);
        applyStimulus(0, 0, 0, 0); checkOutput("mid_reset_3a", 3, 1, 0);
        applyStimulus(0, 0, 0, 0); checkOutput("mid_reset_3b", 3, 1, 0);
        applyStimulus(1, 0, 0, 0); checkOutput("mid_reset_hit", 0, 0, 0);
        applyStimulus(0, 0, 0, 0); checkOutput("mid_reset_nodone", 0, 0, 0);
        applyStimulus(0, 1, 4, 0);
        busy_cycles = busy ? 1 : 0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkModel("fresh_burst");
            if (busy) busy_cycles++;
            if (done) begin
                done_seen++;
                break;
            end
        end
        checkCount("fresh_burst_busy_cycles", busy_cycles, 6);
        checkCount("fresh_burst_done", done_seen, 1);

        // Longest burst: len=15, rep=3, with len/rep disturbed mid-burst.
        applyStimulus(0, 0, 0, 0); checkModel("pre_long");
        applyStimulus(0, 1, 15, 3); checkModel("long_start");
        busy_cycles = busy ? 1 : 0;
        done_seen = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, (i % 7) == 0, 4'(i), 2'(i));
            checkModel("long_burst");
            if (busy) busy_cycles++;
            if (done) begin
                done_seen++;
                break;
            end
        end
        checkCount("long_burst_busy_cycles", busy_cycles, 68);
        checkCount("long_burst_done", done_seen, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r_rand = ($urandom_range(0, 59) == 0);
            s_rand = ($urandom_range(0, 2) == 0);
            applyStimulus(r_rand, s_rand, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            checkModel("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
